// File: rtl/aes_trace_pkg.sv
// -----------------------------------------------------------------------------
// aes_trace_pkg
//
// Shared definitions for the AES trace-capture campaign sequencer:
//   - state_t     : campaign FSM states
//   - LFSR_TAPS   : feedback taps of the 128-bit Galois plaintext LFSR
//                   (polynomial x^128 + x^7 + x^2 + x + 1)
//   - lfsr_next() : one Galois step of that LFSR
// -----------------------------------------------------------------------------
package aes_trace_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RUN  = 3'd1,
        ST_WAIT = 3'd2,
        ST_GAP  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    localparam logic [127:0] LFSR_TAPS = 128'h87;

    // Shift left by one; when the bit falling off the top was set, fold the
    // low-order polynomial terms back in.
    function automatic logic [127:0] lfsr_next(input logic [127:0] p);
        return {p[126:0], 1'b0} ^ (p[127] ? LFSR_TAPS : 128'h0);
    endfunction

endpackage

// File: rtl/aes_lfsr128.sv
// -----------------------------------------------------------------------------
// aes_lfsr128
//
// Plaintext register for the campaign sequencer. Holds the plaintext that is
// presented to the AES core and steps it through the Galois LFSR sequence.
//
// Ports:
//   clk      in   1   rising-edge clock
//   rst      in   1   asynchronous active-high reset (clears value to 0)
//   load     in   1   load load_val (takes priority over advance)
//   load_val in 128  value to load
//   advance  in   1   step the LFSR once
//   fixed    in   1   hold value even when advance is asserted (fixed mode)
//   value    out 128  current plaintext
// -----------------------------------------------------------------------------
module aes_lfsr128
    import aes_trace_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [127:0] load_val,
    input  logic         advance,
    input  logic         fixed,
    output logic [127:0] value
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value <= 128'h0;
        end else if (load) begin
            value <= load_val;
        end else if (advance && !fixed) begin
            value <= lfsr_next(value);
        end
    end

endmodule

// File: rtl/aes_trace_sequencer.sv
// -----------------------------------------------------------------------------
// aes_trace_sequencer
//
// Drives an AES core through a campaign of NUM_VEC encryptions under one key
// for power-trace capture and self-test. Each vector: hold aes_en (and the
// scope trigger) for EN_HOLD cycles, optionally wait up to TIMEOUT cycles for
// the ciphertext, then idle for GAP_CYCLES cycles.
//
// Handshake semantics (single definition for all interfaces of this block):
//   - start is a level sampled only in IDLE; it is ignored while busy.
//   - aes_en is a level request to the core; aes_data/aes_key are stable
//     throughout RUN and WAIT. The core answers with aes_out_valid, which the
//     sequencer accepts without backpressure; only the first valid of a vector
//     seen in RUN or WAIT is taken, all others are dropped.
//   - res_valid is a one-cycle pulse with no ready; res_data/res_idx hold
//     until the next capture.
//
// Parameters:
//   NUM_VEC    vectors per campaign (>=1)
//   EN_HOLD    cycles aes_en stays high per vector (>=1)
//   GAP_CYCLES idle cycles between vectors (>=1)
//   TIMEOUT    cycles after the hold window to wait for aes_out_valid (>=1)
//
// Ports:
//   AES_clk, AES_rst      clock, asynchronous active-high reset
//   start, mode           campaign start; 0 fixed / 1 LFSR plaintext
//   key_in, seed_in       key and first plaintext / seed, latched at start
//   aes_en, aes_data,     core enable, plaintext and key
//   aes_key
//   aes_out_valid,        core ciphertext and its valid
//   aes_out
//   trig                  scope trigger (same as aes_en)
//   busy, done            not-IDLE flag; end-of-campaign pulse
//   res_valid, res_data,  captured ciphertext pulse, value and vector index
//   res_idx
//   timeout_err           sticky: a vector saw no valid in time
// -----------------------------------------------------------------------------
module aes_trace_sequencer
    import aes_trace_pkg::*;
#(
    parameter int  NUM_VEC    = 4,
    parameter int  EN_HOLD    = 51,
    parameter int  GAP_CYCLES = 16,
    parameter int  TIMEOUT    = 64,
    localparam int IDX_W      = (NUM_VEC > 1) ? $clog2(NUM_VEC) : 1
) (
    input  logic             AES_clk,
    input  logic             AES_rst,
    input  logic             start,
    input  logic             mode,
    input  logic [127:0]     key_in,
    input  logic [127:0]     seed_in,
    output logic             aes_en,
    output logic [127:0]     aes_data,
    output logic [127:0]     aes_key,
    input  logic             aes_out_valid,
    input  logic [127:0]     aes_out,
    output logic             trig,
    output logic             busy,
    output logic             done,
    output logic             res_valid,
    output logic [127:0]     res_data,
    output logic [IDX_W-1:0] res_idx,
    output logic             timeout_err
);

    localparam int HOLD_W = (EN_HOLD    > 1) ? $clog2(EN_HOLD)    : 1;
    localparam int GAP_W  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int TO_W   = (TIMEOUT    > 1) ? $clog2(TIMEOUT)    : 1;

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(EN_HOLD - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_CYCLES - 1);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_VEC - 1);

    state_t             state;
    state_t             state_nxt;

    logic [HOLD_W-1:0]  hold_cnt;
    logic [GAP_W-1:0]   gap_cnt;
    logic [TO_W-1:0]    to_cnt;
    logic [IDX_W-1:0]   idx;
    logic               got;
    logic               mode_q;

    logic               load;
    logic               advance;
    logic               capture;
    logic               timeout_set;
    logic               hold_last;
    logic               gap_last;
    logic               to_last;
    logic [127:0]       load_val;

    // Plaintext register
    // A zero seed would lock the LFSR at zero, so random mode starts from 1.
    assign load_val = (mode && (seed_in == 128'h0)) ? 128'h1 : seed_in;

    aes_lfsr128 u_lfsr (
        .clk      (AES_clk),
        .rst      (AES_rst),
        .load     (load),
        .load_val (load_val),
        .advance  (advance),
        .fixed    (!mode_q),
        .value    (aes_data)
    );

    // Decodes
    assign hold_last = (hold_cnt == HOLD_LAST);
    assign gap_last  = (gap_cnt  == GAP_LAST);
    assign to_last   = (to_cnt   == TO_LAST);

    // First valid of the vector while the core is being driven or awaited.
    assign capture = aes_out_valid && !got &&
                     ((state == ST_RUN) || (state == ST_WAIT));

    // A valid on the final WAIT cycle wins over the timeout.
    assign timeout_set = (state == ST_WAIT) && to_last && !aes_out_valid;

    // Outputs decoded straight from state so that an asynchronous reset
    // drops them immediately.
    assign aes_en = (state == ST_RUN);
    assign trig   = aes_en;
    assign busy   = (state != ST_IDLE);
    assign done   = (state == ST_DONE);

    // FSM: state register
    always_ff @(posedge AES_clk or posedge AES_rst) begin
        if (AES_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM: next state and strobes
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        advance   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                // A capture on the last hold cycle also skips WAIT.
                if (hold_last) begin
                    state_nxt = (got || capture) ? ST_GAP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (capture || to_last) begin
                    state_nxt = ST_GAP;
                end
            end
            ST_GAP: begin
                if (gap_last) begin
                    if (idx == IDX_LAST) begin
                        state_nxt = ST_DONE;
                    end else begin
                        advance   = 1'b1;
                        state_nxt = ST_RUN;
                    end
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Per-phase cycle counters; each runs only in its own state and is
    // cleared on the cycle it expires or whenever its state is left.
    always_ff @(posedge AES_clk or posedge AES_rst) begin
        if (AES_rst) begin
            hold_cnt <= '0;
            gap_cnt  <= '0;
            to_cnt   <= '0;
        end else begin
            if ((state == ST_RUN) && !hold_last) begin
                hold_cnt <= hold_cnt + 1'b1;
            end else begin
                hold_cnt <= '0;
            end

            if ((state == ST_GAP) && !gap_last) begin
                gap_cnt <= gap_cnt + 1'b1;
            end else begin
                gap_cnt <= '0;
            end

            if ((state == ST_WAIT) && !to_last && !capture) begin
                to_cnt <= to_cnt + 1'b1;
            end else begin
                to_cnt <= '0;
            end
        end
    end

    // Campaign context, capture and error registers
    always_ff @(posedge AES_clk or posedge AES_rst) begin
        if (AES_rst) begin
            idx         <= '0;
            got         <= 1'b0;
            mode_q      <= 1'b0;
            aes_key     <= 128'h0;
            timeout_err <= 1'b0;
            res_valid   <= 1'b0;
            res_data    <= 128'h0;
            res_idx     <= '0;
        end else begin
            res_valid <= capture;

            if (load) begin
                idx         <= '0;
                got         <= 1'b0;
                mode_q      <= mode;
                aes_key     <= key_in;
                timeout_err <= 1'b0;
            end else begin
                if (advance) begin
                    idx <= idx + 1'b1;
                    got <= 1'b0;
                end else if (capture) begin
                    got <= 1'b1;
                end
                if (timeout_set) begin
                    timeout_err <= 1'b1;
                end
            end

            if (capture) begin
                res_data <= aes_out;
                res_idx  <= idx;
            end
        end
    end

endmodule

// File: tb/tb_aes_trace_sequencer.sv
`timescale 1ns/1ps
module tb_aes_trace_sequencer;

    localparam int NV = 4;
    localparam int EH = 51;
    localparam int GC = 16;
    localparam int TO = 64;
    localparam int IW = 2;
    localparam int EW = 16 + IW + 128;
    localparam int NX = 3;

    // ---------------- clock / reset / DUT ----------------
    logic           AES_clk = 1'b0;
    logic           AES_rst;
    logic           start;
    logic           mode;
    logic [127:0]   key_in;
    logic [127:0]   seed_in;
    logic           aes_en;
    logic [127:0]   aes_data;
    logic [127:0]   aes_key;
    logic           aes_out_valid;
    logic [127:0]   aes_out;
    logic           trig;
    logic           busy;
    logic           done;
    logic           res_valid;
    logic [127:0]   res_data;
    logic [IW-1:0]  res_idx;
    logic           timeout_err;

    always #5 AES_clk = ~AES_clk;

    aes_trace_sequencer #(
        .NUM_VEC    (NV),
        .EN_HOLD    (EH),
        .GAP_CYCLES (GC),
        .TIMEOUT    (TO)
    ) dut (
        .AES_clk       (AES_clk),
        .AES_rst       (AES_rst),
        .start         (start),
        .mode          (mode),
        .key_in        (key_in),
        .seed_in       (seed_in),
        .aes_en        (aes_en),
        .aes_data      (aes_data),
        .aes_key       (aes_key),
        .aes_out_valid (aes_out_valid),
        .aes_out       (aes_out),
        .trig          (trig),
        .busy          (busy),
        .done          (done),
        .res_valid     (res_valid),
        .res_data      (res_data),
        .res_idx       (res_idx),
        .timeout_err   (timeout_err)
    );

    // ---------------- scoreboard state ----------------
    int             checks   = 0;
    int             failures = 0;
    logic [EW-1:0]  exp_q[$];

    // Stub-core plan per vector, offsets counted from the first aes_en cycle.
    int             off1[NV];        // first valid (captured), -1 = never
    int             offx[NV][NX];    // extra valids that must be ignored
    logic [127:0]   cdat[NV];
    logic [127:0]   junk[NV];

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Reference LFSR step written from the polynomial definition.
    function automatic logic [127:0] model_next(input logic [127:0] p);
        logic [127:0] n;
        n = p << 1;
        if (p[127]) n = n ^ 128'h87;
        return n;
    endfunction

    function automatic int vec_len(input int o1);
        if (o1 < 0) return EH + TO + GC;
        if (o1 < EH) return EH + GC;
        return EH + (o1 - EH + 1) + GC;
    endfunction

    // Extra pulses: two anywhere after the first valid (or after the timeout),
    // and one inside the gap.
    task automatic pick_extras(input int v);
        int len, lo, busy_end;
        len      = vec_len(off1[v]);
        lo       = (off1[v] >= 0) ? off1[v] + 1 : EH + TO;
        busy_end = len - GC;
        for (int j = 0; j < 2; j++)
            offx[v][j] = ($urandom_range(0, 1) == 1) ? int'($urandom_range(lo, len - 1)) : -1;
        offx[v][2] = ($urandom_range(0, 1) == 1) ? int'($urandom_range(busy_end, len - 1)) : -1;
    endtask

    // kind 0: random mix incl. boundaries, 1: valid at offset 10 only, 2: never valid
    task automatic gen_plan(input int kind);
        for (int v = 0; v < NV; v++) begin
            cdat[v] = rand128();
            junk[v] = ~cdat[v];
            case (kind)
                1: off1[v] = 10;
                2: off1[v] = -1;
                default: begin
                    case ($urandom_range(0, 4))
                        0: off1[v] = int'($urandom_range(0, EH - 1));
                        1: off1[v] = int'($urandom_range(EH, EH + TO - 1));
                        2: off1[v] = -1;
                        3: off1[v] = EH - 1;
                        default: off1[v] = EH + TO - 1;
                    endcase
                end
            endcase
            if (kind == 1) begin
                for (int j = 0; j < NX; j++) offx[v][j] = -1;
            end else begin
                pick_extras(v);
            end
        end
    endtask

    // ---------------- driver + checker for one campaign ----------------
    task automatic run_campaign(input logic m, input logic [127:0] k, input logic [127:0] s,
                                input int rst_vec, input bit busy_start);
        logic [127:0] pt[NV];
        int           vstart[NV+1];
        int           done_cyc, to_cyc, bs_cyc, rst_at, sv, off, cur;
        logic         prev_en, en_exp, rv_exp;
        logic [EW-1:0] e;

        pt[0] = (m && s == 128'h0) ? 128'h1 : s;
        for (int v = 1; v < NV; v++) pt[v] = m ? model_next(pt[v-1]) : pt[v-1];

        exp_q.delete();
        vstart[0] = 1;
        to_cyc    = 1 << 30;
        for (int v = 0; v < NV; v++) begin
            if (off1[v] < 0) begin
                if (to_cyc == (1 << 30)) to_cyc = vstart[v] + EH + TO;
            end else begin
                exp_q.push_back({16'(vstart[v] + off1[v] + 1), IW'(v), cdat[v]});
            end
            vstart[v+1] = vstart[v] + vec_len(off1[v]);
        end
        done_cyc = vstart[NV];
        bs_cyc   = busy_start ? int'($urandom_range(2, done_cyc - 1)) : -1;
        rst_at   = (rst_vec >= 0) ? vstart[rst_vec] + 5 : -1;

        start = 1'b1; mode = m; key_in = k; seed_in = s;
        aes_out_valid = 1'b0;
        sv = -1; off = 0; prev_en = 1'b0;

        for (int cyc = 1; cyc <= done_cyc + 2; cyc++) begin
            @(posedge AES_clk); #1;
            // Inputs other than start must be ignored once latched.
            start   = 1'b0;
            mode    = 1'($urandom_range(0, 1));
            key_in  = rand128();
            seed_in = rand128();

            en_exp = 1'b0; cur = 0;
            for (int v = 0; v < NV; v++) begin
                if (cyc >= vstart[v] && cyc < vstart[v] + EH) en_exp = 1'b1;
                if (cyc >= vstart[v]) cur = v;
            end
            check("ctl", 128'({aes_en, trig, busy, done, timeout_err}),
                  128'({en_exp, en_exp, (cyc <= done_cyc), (cyc == done_cyc), (cyc >= to_cyc)}));
            if (cyc <= done_cyc) begin
                check("aes_key", aes_key, k);
                check("aes_data", aes_data, pt[cur]);
            end

            rv_exp = (exp_q.size() > 0) && (int'(exp_q[0][EW-1 -: 16]) == cyc);
            check("res_valid", 128'(res_valid), 128'(rv_exp));
            if (res_valid && rv_exp) begin
                e = exp_q.pop_front();
                check("res_idx", 128'(res_idx), 128'(e[128 +: IW]));
                check("res_data", res_data, e[127:0]);
            end

            if (cyc == rst_at) begin
                #2 AES_rst = 1'b1;
                #1;
                check("rst_ctl", 128'({aes_en, trig, busy, done, res_valid, timeout_err}), 128'h0);
                check("rst_data", aes_data, 128'h0);
                check("rst_key", aes_key, 128'h0);
                check("rst_res", res_data, 128'h0);
                check("rst_idx", 128'(res_idx), 128'h0);
                aes_out_valid = 1'b0;
                @(posedge AES_clk); #1;
                AES_rst = 1'b0;
                check("rst_hold_done", 128'({busy, done}), 128'h0);
                return;
            end

            // Stub core: tracks vectors by aes_en rising edges.
            if (aes_en && !prev_en) begin
                sv++;
                off = 0;
            end else begin
                off++;
            end
            prev_en = aes_en;
            aes_out_valid = 1'b0;
            aes_out       = rand128();
            if (sv >= 0 && sv < NV) begin
                if (off == off1[sv]) begin
                    aes_out_valid = 1'b1;
                    aes_out       = cdat[sv];
                end else begin
                    for (int j = 0; j < NX; j++) begin
                        if (off == offx[sv][j]) begin
                            aes_out_valid = 1'b1;
                            aes_out       = junk[sv];
                        end
                    end
                end
            end
            if (cyc == bs_cyc) start = 1'b1;
        end
        aes_out_valid = 1'b0;
        check("res_missing", 128'(exp_q.size()), 128'h0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        AES_rst = 1'b1; start = 1'b0; mode = 1'b0;
        key_in = 128'h0; seed_in = 128'h0;
        aes_out_valid = 1'b0; aes_out = 128'h0;
        repeat (3) @(posedge AES_clk);
        #1;
        check("reset_ctl", 128'({aes_en, trig, busy, done, res_valid, timeout_err}), 128'h0);
        check("reset_data", aes_data, 128'h0);
        check("reset_key", aes_key, 128'h0);
        check("reset_res", res_data, 128'h0);
        check("reset_idx", 128'(res_idx), 128'h0);
        AES_rst = 1'b0;
        @(posedge AES_clk); #1;

        // Known-answer vector with fixed plaintext, valid 10 cycles into RUN.
        gen_plan(1);
        cdat[0] = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
        run_campaign(1'b0, 128'h000102030405060708090a0b0c0d0e0f,
                     128'h00112233445566778899aabbccddeeff, -1, 1'b0);

        // Random mode, zero seed: plaintexts 1,2,4,8.
        gen_plan(0);
        run_campaign(1'b1, rand128(), 128'h0, -1, 1'b1);

        // Top bit set: feedback taps fold in on the first step.
        gen_plan(0);
        run_campaign(1'b1, rand128(), {1'b1, 127'h0}, -1, 1'b0);

        // Core never answers; only gap pulses, which must be ignored.
        gen_plan(2);
        run_campaign(1'b0, rand128(), rand128(), -1, 1'b1);

        // Boundaries: valid on last RUN cycle, last WAIT cycle, first WAIT
        // cycle, first RUN cycle, each followed by ignored pulses.
        gen_plan(0);
        off1[0] = EH - 1; off1[1] = EH + TO - 1; off1[2] = EH; off1[3] = 0;
        for (int v = 0; v < NV; v++) pick_extras(v);
        run_campaign(1'($urandom_range(0, 1)), rand128(), rand128(), -1, 1'b1);

        // Asynchronous reset in the middle of vector 2's RUN, then restart.
        gen_plan(1);
        run_campaign(1'b1, rand128(), rand128(), 2, 1'b0);
        gen_plan(1);
        run_campaign(1'b1, rand128(), 128'h5, -1, 1'b0);

        for (int n = 0; n < 6; n++) begin
            gen_plan(0);
            run_campaign(1'($urandom_range(0, 1)), rand128(), rand128(), -1, 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/aes_trace_sequencer.md
# aes_trace_sequencer

Synthesizable campaign sequencer that drives an `AES_top` instance through a parametrised series of encryptions under one key, for power/VCD trace capture and on-chip self-test. It sits between a host/register front end and the AES core. It generates fixed or LFSR-random plaintexts, holds `AES_en` for a programmed window, emits a scope trigger, and captures one ciphertext per vector with a timeout guard.

## Interface

Parameters:
- `NUM_VEC`, 4: vectors per campaign (≥1).
- `EN_HOLD`, 51: cycles `aes_en` stays high per vector (≥1).
- `GAP_CYCLES`, 16: idle cycles between vectors (≥1).
- `TIMEOUT`, 64: extra cycles after the `EN_HOLD` window to wait for `aes_out_valid` (≥1).

Ports:
- `AES_clk` in 1: single clock, rising edge.
- `AES_rst` in 1: asynchronous, active-high reset.
- `start` in 1: campaign start. Sampled only in IDLE.
- `mode` in 1: 0 = fixed plaintext (`seed_in` every vector); 1 = LFSR-random plaintext. Latched at start.
- `key_in` in 128: key, latched at start.
- `seed_in` in 128: first plaintext / LFSR seed, latched at start.
- `aes_en` out 1: enable to the AES core.
- `aes_data` out 128: plaintext to the core.
- `aes_key` out 128: latched key.
- `aes_out_valid` in 1: core output valid.
- `aes_out` in 128: core ciphertext.
- `trig` out 1: scope trigger, equal to `aes_en`.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse at campaign end.
- `res_valid` out 1: one-cycle pulse when a ciphertext is captured.
- `res_data` out 128: captured ciphertext, held until the next capture.
- `res_idx` out IDX_W: vector index of `res_data`, where IDX_W = max(1, $clog2(NUM_VEC)).
- `timeout_err` out 1: sticky. Set by any vector timeout, cleared by reset or start.

## Operation

- States: IDLE, RUN, WAIT, GAP, DONE.
- IDLE:
  - On `start`, latch `key_in`, `seed_in` and `mode`.
  - Load plaintext = seed. In mode 1 a zero seed is replaced by 128'h1.
  - Clear `idx`, `timeout_err` and the per-vector `got` flag. Go to RUN.
- RUN: `aes_en`=1 for exactly `EN_HOLD` cycles, then go to GAP if `got`, else to WAIT.
- WAIT: `aes_en`=0.
  - On `aes_out_valid`, capture and go to GAP.
  - After `TIMEOUT` cycles with no valid, set `timeout_err` and go to GAP without issuing `res_valid`.
- GAP: `aes_en`=0 for `GAP_CYCLES` cycles.
  - If `idx`==NUM_VEC-1, go to DONE.
  - Otherwise `idx`++, advance the plaintext in mode 1 (fixed in mode 0), clear `got`, and go to RUN.
- DONE: `done`=1 for one cycle, then go to IDLE.
- Capture rule: only the first `aes_out_valid` per vector is captured, seen in RUN or WAIT. It sets `got`, `res_data`=`aes_out`, `res_idx`=`idx`, and a `res_valid` pulse on the next cycle. Later valids for the same vector, and any valid in GAP, DONE or IDLE, are ignored.
- LFSR: 128-bit Galois, polynomial x^128+x^7+x^2+x+1.
  - next = (p<<1) ^ (p[127] ? 128'h87 : 0).
  - Advances once per vector transition.
- `start` while `busy` is ignored.
- `aes_data` and `aes_key` are stable for the whole of RUN and WAIT.

## Timing

- Reset values: state IDLE, all outputs 0 (including `aes_data`, `aes_key`, `res_data`, `res_idx`), counters 0. Reset applies asynchronously, mid-campaign included: `aes_en`/`trig` drop immediately, and no `done` is emitted.
- `start` high at edge N gives `busy`=1, `aes_en`=1 and valid `aes_data` from edge N+1.
- Per vector with a timely valid: `EN_HOLD` + `GAP_CYCLES` cycles.
- A timed-out vector takes `EN_HOLD` + `TIMEOUT` + `GAP_CYCLES` cycles.
- `done` follows the last GAP cycle. `busy` falls the cycle after `done`.
- If valid coincides with the last RUN cycle, it is captured and WAIT is skipped.
- If valid coincides with the last WAIT cycle, capture wins and no timeout is flagged.

## Structure

- Package `aes_trace_pkg` holds:
  - the state enum,
  - `LFSR_TAPS` = 128'h87,
  - function `lfsr_next`.
- Sub-module `aes_lfsr128` holds the plaintext register: load, advance and fixed-hold controls.
- The top holds the FSM, hold/gap/timeout counters sized by `$clog2` of each parameter, and the capture registers.

## Test plan

- FIPS-197, real `AES_top`, NUM_VEC=1, mode 0, key 000102…0f, seed 00112233…ff:
  - `res_data`=69c4e0d86a7b0430d8cdb78070b4c55a, `res_idx`=0.
  - `done` after 51+16 cycles, `timeout_err`=0.
- NUM_VEC=4, mode 0, stub core giving valid 10 cycles into RUN:
  - `aes_data` constant across all vectors, `res_idx` 0,1,2,3.
  - `aes_en` high exactly 51 cycles per vector and low 16 between.
- Mode 1, seed 0, NUM_VEC=4: plaintexts 1, 2, 4, 8. A seed of 128'h8000…0 gives next 128'h87.
- Stub never asserts valid, NUM_VEC=2:
  - `timeout_err` rises 51+64 cycles after start, with no `res_valid`.
  - `done` arrives after 2×(51+64+16) cycles.
- Stub asserts valid 3 times in one vector, plus one pulse in GAP: exactly one `res_valid`, carrying the first value. A `start` pulse while busy has no effect.
- `AES_rst` asserted mid-RUN of vector 2:
  - All outputs 0 immediately.
  - After release, a new `start` restarts at `res_idx` 0 with the seed plaintext.
